uart_tx: RTL and testbench

Buffered UART transmitter driving the board's `RsTx` pin, the outbound counterpart of the serial receive line. Accepts bytes from the core or debug logic over a valid/ready handshake, queues them in a small FIFO, and serialises each as 8N1 (or 8E1, see Configuration) frames, LSB first, at a fixed baud set by a clock-divider parameter. Frames are sent back to back with no idle gap while the FIFO is non-empty.

---
 rtl/uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a shift-register serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (8E1).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic       push, pop, baud_end, fifo_empty;
  logic [7:0] head;

  assign fifo_empty = (count_q == '0);
  // Ready looks only at the stored count, so a full FIFO never passes a byte through.
  assign tx_ready   = (count_q != FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr_q];
  assign baud_end   = (baud_q == BAUD_LAST);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    baud_d    = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
        else          baud_d  = baud_q + 1'b1;
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is registered from the next state so tx changes on the same edge as the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=16; a line sampler decodes frames.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [4:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  int         ncyc = 0;
  int         peak = 0;
  bit         in_frame = 1'b0;
  int         fcyc = 0;
  int         mb = 0;
  logic [7:0] fsh = 8'h00;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line sampler: detects start bits and samples each bit mid-period.
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (!reset_n) in_frame = 1'b0;
    else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        fcyc = 0;
        start_q.push_back(ncyc);
      end
    end else fcyc++;
    if (in_frame && (fcyc % CPB) == CPB / 2) begin
      mb = fcyc / CPB;
      if (mb == 0) begin
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rx_start: got %b want 0", tx); end
      end else if (mb <= 8) begin
        fsh[mb-1] = tx;
      end else if (mb == FB - 1) begin
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rx_stop: got %b want 1", tx); end
        rx_q.push_back(fsh);
        in_frame = 1'b0;
      end else begin
        n_checks++;
        if (tx !== ^fsh) begin n_fail++; $display("FAIL rx_parity: got %b want %b", tx, ^fsh); end
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] d, input int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: tx_ready=%b want 1", tx_ready);
    end
    @(posedge clk);
  endtask

  task automatic release_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy=%b want 0", busy); end
  endtask

  // Call right after push_byte returns at the push edge, FIFO previously empty and idle.
  task automatic check_frame(input logic [7:0] d, input string name);
    logic e;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL %s_pre_tx: got %b want 1", name, tx); end
    n_checks++;
    if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL %s_pre_count: got %0d want 1", name, fifo_count); end
    @(negedge clk);
    tx_valid = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      e = frame_bit(d, c);
      n_checks++;
      if (tx !== e) begin n_fail++; $display("FAIL %s_bit: cycle %0d got %b want %b", name, c, tx, e); end
      if (c == 0) begin
        n_checks++;
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL %s_popped: count %0d want 0", name, fifo_count); end
      end
      if (c == 0 || c == FRAME - 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: cycle %0d got %b want 1", name, c, busy); end
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL %s_idle_tx: got %b want 1", name, tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_done_busy: got %b want 0", name, busy); end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL %s_tx: got %b want 1", name, tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", name, tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", name, busy); end
    n_checks++;
    if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL %s_count: got %0d want 0", name, fifo_count); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check_idle_outputs("reset_released");
    n_checks++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL reset_no_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_single();
    int w;
    rx_q.delete();
    push_byte(8'h55, w);
    check_frame(8'h55, "single");
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_fail++; $display("FAIL single_rx: got %0d frames first %h want 1 frame 55", rx_q.size(), rx_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    rx_q.delete();
    start_q.delete();
    peak = 0;
    push_byte(8'hA3, w);
    push_byte(8'h0F, w);
    release_valid();
    wait_idle(4 * FRAME);
    n_checks++;
    if (rx_q.size() != 2) begin n_fail++; $display("FAIL b2b_frames: got %0d want 2", rx_q.size()); end
    n_checks++;
    if (rx_q[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_first: got %h want a3", rx_q[0]); end
    n_checks++;
    if (rx_q[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_second: got %h want 0f", rx_q[1]); end
    n_checks++;
    if (start_q[1] - start_q[0] != FRAME) begin
      n_fail++; $display("FAIL b2b_gap: start spacing %0d want %0d", start_q[1] - start_q[0], FRAME);
    end
    n_checks++;
    if (peak != 1) begin n_fail++; $display("FAIL b2b_peak: got %0d want 1", peak); end
  endtask

  task automatic test_fifo_full();
    int         w;
    logic [7:0] exp_b [18];
    rx_q.delete();
    peak = 0;
    for (int i = 0; i < 18; i++) exp_b[i] = 8'(i * 29 + 5);
    for (int i = 0; i < 17; i++) push_byte(exp_b[i], w);
    #1;
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", tx_ready); end
    n_checks++;
    if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", fifo_count); end
    // First byte popped at push edge 2; second pops at edge 2+FRAME; the 18th call starts after edge 17.
    push_byte(exp_b[17], w);
    n_checks++;
    if (w != FRAME - 15) begin n_fail++; $display("FAIL full_stall: waited %0d want %0d", w, FRAME - 15); end
    release_valid();
    wait_idle(20 * FRAME);
    n_checks++;
    if (rx_q.size() != 18) begin n_fail++; $display("FAIL full_frames: got %0d want 18", rx_q.size()); end
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL full_order: idx %0d got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    n_checks++;
    if (peak != 16) begin n_fail++; $display("FAIL full_peak: got %0d want 16", peak); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w;
    rx_q.delete();
    push_byte(8'h07, w);
    check_frame(8'h07, "parity_07");
    push_byte(8'h03, w);
    check_frame(8'h03, "parity_03");
    n_checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h07 || rx_q[1] !== 8'h03) begin
      n_fail++; $display("FAIL parity_rx: got %0d frames %h %h want 07 03", rx_q.size(), rx_q[0], rx_q[1]);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int w;
    rx_q.delete();
    push_byte(8'hFF, w);
    push_byte(8'h11, w);
    push_byte(8'h22, w);
    push_byte(8'h33, w);
    @(negedge clk);
    tx_valid = 1'b0;
    // Frame cycle 2 now; cycle 17 lies inside data bit 3.
    repeat (15) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_bit3: got %b want 1", tx); end
    n_checks++;
    if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL mid_queued: got %0d want 3", fifo_count); end
    #1 reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rx_q.delete();
    push_byte(8'h81, w);
    check_frame(8'h81, "post_reset");
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
      n_fail++; $display("FAIL post_reset_rx: got %0d frames first %h want 1 frame 81", rx_q.size(), rx_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
